// File: rtl/sc_statemachine_player_pkg.sv
// Shared encodings for the Frogger player-position controller: FSM states,
// shift command codes and the recorded move direction.
package sc_statemachine_player_pkg;

    localparam logic [3:0] ST_RESET = 4'd0;
    localparam logic [3:0] ST_IDLE  = 4'd1;
    localparam logic [3:0] ST_INIT  = 4'd2;
    localparam logic [3:0] ST_UP    = 4'd3;
    localparam logic [3:0] ST_DOWN  = 4'd4;
    localparam logic [3:0] ST_LEFT  = 4'd5;
    localparam logic [3:0] ST_RIGHT = 4'd6;
    localparam logic [3:0] ST_HOLD  = 4'd7;

    typedef enum logic [3:0] {
        S_RESET = ST_RESET,
        S_IDLE  = ST_IDLE,
        S_INIT  = ST_INIT,
        S_UP    = ST_UP,
        S_DOWN  = ST_DOWN,
        S_LEFT  = ST_LEFT,
        S_RIGHT = ST_RIGHT,
        S_HOLD  = ST_HOLD
    } state_e;

    localparam logic [1:0] SHIFT_LEFT  = 2'b01;
    localparam logic [1:0] SHIFT_RIGHT = 2'b10;
    localparam logic [1:0] SHIFT_HOLD  = 2'b11;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_e;

    // Action state that re-issues a recorded move on auto-repeat.
    function automatic state_e dir_action(input dir_e dir);
        case (dir)
            DIR_UP:    return S_UP;
            DIR_DOWN:  return S_DOWN;
            DIR_LEFT:  return S_LEFT;
            DIR_RIGHT: return S_RIGHT;
            default:   return S_HOLD;
        endcase
    endfunction

endpackage

// File: rtl/sc_statemachine_player_repeat_timer.sv
// Saturating hold-time counter for auto-repeat; flags the terminal count at
// REPEAT_CYCLES-1 and collapses to a constant-low flag when repeat is disabled.
module sc_repeat_timer #(
    parameter int REPEAT_CYCLES = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    generate
        if (REPEAT_CYCLES == 0) begin : g_off
            logic unused_s;
            assign unused_s = ^{clk, rst, clr, inc};
            assign tc       = 1'b0;
        end else begin : g_on
            localparam int CW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
            localparam logic [CW-1:0] TC_VAL = CW'(REPEAT_CYCLES - 1);

            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;

            // Counter next value: clear wins, then increment up to the terminal count.
            always_comb begin
                cnt_d = cnt_q;
                if (clr) begin
                    cnt_d = '0;
                end else if (inc && (cnt_q != TC_VAL)) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end

            // Counter register with synchronous reset.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign tc = (cnt_q == TC_VAL);
        end
    endgenerate

endmodule

// File: rtl/sc_statemachine_player.sv
// Player-position controller: turns active-low buttons into one-cycle playfield
// commands, tracks row/column so edge moves are blocked, and auto-repeats held moves.
module sc_statemachine_player
    import sc_statemachine_player_pkg::*;
#(
    parameter int ROWS          = 8,
    parameter int COLS          = 8,
    parameter int START_COL     = 3,
    parameter int REPEAT_CYCLES = 0
) (
    input  logic                     SC_STATEMACHINEPLAYER_CLOCK_50,
    input  logic                     SC_STATEMACHINEPLAYER_RESET_InHigh,
    input  logic                     SC_STATEMACHINEPLAYER_startGame_InLow,
    input  logic                     SC_STATEMACHINEPLAYER_upButton_InLow,
    input  logic                     SC_STATEMACHINEPLAYER_downButton_InLow,
    input  logic                     SC_STATEMACHINEPLAYER_leftButton_InLow,
    input  logic                     SC_STATEMACHINEPLAYER_rightButton_InLow,
    output logic                     SC_STATEMACHINEPLAYER_clear_OutLow,
    output logic                     SC_STATEMACHINEPLAYER_load0_OutLow,
    output logic                     SC_STATEMACHINEPLAYER_load1_OutLow,
    output logic [1:0]               SC_STATEMACHINEPLAYER_shiftselection_Out,
    output logic [$clog2(ROWS)-1:0]  SC_STATEMACHINEPLAYER_row_Out,
    output logic [$clog2(COLS)-1:0]  SC_STATEMACHINEPLAYER_col_Out
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam logic [RW-1:0] ROW_MAX   = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_MAX   = CW'(COLS - 1);
    localparam logic [CW-1:0] COL_START = CW'(START_COL);

    logic clk;
    logic rst;
    assign clk = SC_STATEMACHINEPLAYER_CLOCK_50;
    assign rst = SC_STATEMACHINEPLAYER_RESET_InHigh;

    state_e        state_q, state_d;
    dir_e          dir_q, dir_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          clear_q, clear_d, load0_q, load0_d, load1_q, load1_d;
    logic [1:0]    shift_q, shift_d;

    logic start_s, up_s, down_s, left_s, right_s, all_released_s;
    logic can_up_s, can_down_s, can_left_s, can_right_s;
    logic repeat_ok_s, rep_tc_s, rep_clr_s;

    assign start_s        = ~SC_STATEMACHINEPLAYER_startGame_InLow;
    assign up_s           = ~SC_STATEMACHINEPLAYER_upButton_InLow;
    assign down_s         = ~SC_STATEMACHINEPLAYER_downButton_InLow;
    assign left_s         = ~SC_STATEMACHINEPLAYER_leftButton_InLow;
    assign right_s        = ~SC_STATEMACHINEPLAYER_rightButton_InLow;
    assign all_released_s = ~(start_s | up_s | down_s | left_s | right_s);

    assign can_up_s    = (row_q < ROW_MAX);
    assign can_down_s  = (row_q > RW'(0));
    assign can_left_s  = (col_q > CW'(0));
    assign can_right_s = (col_q < COL_MAX);

    // The recorded direction may repeat only while its button is held and the edge allows it.
    always_comb begin
        repeat_ok_s = 1'b0;
        case (dir_q)
            DIR_UP:    repeat_ok_s = up_s    & can_up_s;
            DIR_DOWN:  repeat_ok_s = down_s  & can_down_s;
            DIR_LEFT:  repeat_ok_s = left_s  & can_left_s;
            DIR_RIGHT: repeat_ok_s = right_s & can_right_s;
            default:   repeat_ok_s = 1'b0;
        endcase
    end

    // Next state, recorded direction and position update on leaving an action state.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        row_d   = row_q;
        col_d   = col_q;
        case (state_q)
            S_RESET: state_d = S_IDLE;
            S_IDLE: begin
                if (start_s) begin
                    state_d = S_INIT;
                end else if (up_s && can_up_s) begin
                    state_d = S_UP;
                end else if (down_s && can_down_s) begin
                    state_d = S_DOWN;
                end else if (left_s && can_left_s) begin
                    state_d = S_LEFT;
                end else if (right_s && can_right_s) begin
                    state_d = S_RIGHT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_INIT: begin
                state_d = S_HOLD;
                dir_d   = DIR_NONE;
                row_d   = '0;
                col_d   = COL_START;
            end
            S_UP: begin
                state_d = S_HOLD;
                dir_d   = DIR_UP;
                row_d   = row_q + RW'(1);
            end
            S_DOWN: begin
                state_d = S_HOLD;
                dir_d   = DIR_DOWN;
                row_d   = row_q - RW'(1);
            end
            S_LEFT: begin
                state_d = S_HOLD;
                dir_d   = DIR_LEFT;
                col_d   = col_q - CW'(1);
            end
            S_RIGHT: begin
                state_d = S_HOLD;
                dir_d   = DIR_RIGHT;
                col_d   = col_q + CW'(1);
            end
            S_HOLD: begin
                if (all_released_s) begin
                    state_d = S_IDLE;
                end else if (rep_tc_s && repeat_ok_s) begin
                    state_d = dir_action(dir_q);
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: state_d = S_RESET;
        endcase
    end

    // Outputs are decoded from the next state so the registered pulse lines up with the state.
    always_comb begin
        clear_d = 1'b1;
        load0_d = 1'b1;
        load1_d = 1'b1;
        shift_d = SHIFT_HOLD;
        case (state_d)
            S_INIT:  clear_d = 1'b0;
            S_UP:    load0_d = 1'b0;
            S_DOWN:  load1_d = 1'b0;
            S_LEFT:  shift_d = SHIFT_LEFT;
            S_RIGHT: shift_d = SHIFT_RIGHT;
            default: shift_d = SHIFT_HOLD;
        endcase
    end

    // Counter runs only across consecutive HOLD cycles; any entry or exit restarts it.
    assign rep_clr_s = (state_q != S_HOLD) || (state_d != S_HOLD);

    sc_repeat_timer #(
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_repeat_timer (
        .clk (clk),
        .rst (rst),
        .clr (rep_clr_s),
        .inc (~rep_clr_s),
        .tc  (rep_tc_s)
    );

    // State, position and output registers; reset overrides every pending update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RESET;
            dir_q   <= DIR_NONE;
            row_q   <= '0;
            col_q   <= COL_START;
            clear_q <= 1'b1;
            load0_q <= 1'b1;
            load1_q <= 1'b1;
            shift_q <= SHIFT_HOLD;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            row_q   <= row_d;
            col_q   <= col_d;
            clear_q <= clear_d;
            load0_q <= load0_d;
            load1_q <= load1_d;
            shift_q <= shift_d;
        end
    end

    assign SC_STATEMACHINEPLAYER_clear_OutLow       = clear_q;
    assign SC_STATEMACHINEPLAYER_load0_OutLow       = load0_q;
    assign SC_STATEMACHINEPLAYER_load1_OutLow       = load1_q;
    assign SC_STATEMACHINEPLAYER_shiftselection_Out = shift_q;
    assign SC_STATEMACHINEPLAYER_row_Out            = row_q;
    assign SC_STATEMACHINEPLAYER_col_Out            = col_q;

endmodule

// File: tb/tb_sc_statemachine_player.sv
// Bench for sc_statemachine_player: one instance without auto-repeat and one with
// REPEAT_CYCLES = 4, driven cycle by cycle from per-scenario step plans.
module tb_sc_statemachine_player;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic st_n = 1'b1, up_n = 1'b1, dn_n = 1'b1, lf_n = 1'b1, rt_n = 1'b1;

    logic       clr0, ld00, ld10, clr4, ld04, ld14;
    logic [1:0] sh0, sh4;
    logic [2:0] row0, col0, row4, col4;

    always #5 clk = ~clk;

    sc_statemachine_player dut0 (
        .SC_STATEMACHINEPLAYER_CLOCK_50          (clk),
        .SC_STATEMACHINEPLAYER_RESET_InHigh      (rst),
        .SC_STATEMACHINEPLAYER_startGame_InLow   (st_n),
        .SC_STATEMACHINEPLAYER_upButton_InLow    (up_n),
        .SC_STATEMACHINEPLAYER_downButton_InLow  (dn_n),
        .SC_STATEMACHINEPLAYER_leftButton_InLow  (lf_n),
        .SC_STATEMACHINEPLAYER_rightButton_InLow (rt_n),
        .SC_STATEMACHINEPLAYER_clear_OutLow      (clr0),
        .SC_STATEMACHINEPLAYER_load0_OutLow      (ld00),
        .SC_STATEMACHINEPLAYER_load1_OutLow      (ld10),
        .SC_STATEMACHINEPLAYER_shiftselection_Out(sh0),
        .SC_STATEMACHINEPLAYER_row_Out           (row0),
        .SC_STATEMACHINEPLAYER_col_Out           (col0)
    );

    sc_statemachine_player #(.REPEAT_CYCLES(4)) dut4 (
        .SC_STATEMACHINEPLAYER_CLOCK_50          (clk),
        .SC_STATEMACHINEPLAYER_RESET_InHigh      (rst),
        .SC_STATEMACHINEPLAYER_startGame_InLow   (st_n),
        .SC_STATEMACHINEPLAYER_upButton_InLow    (up_n),
        .SC_STATEMACHINEPLAYER_downButton_InLow  (dn_n),
        .SC_STATEMACHINEPLAYER_leftButton_InLow  (lf_n),
        .SC_STATEMACHINEPLAYER_rightButton_InLow (rt_n),
        .SC_STATEMACHINEPLAYER_clear_OutLow      (clr4),
        .SC_STATEMACHINEPLAYER_load0_OutLow      (ld04),
        .SC_STATEMACHINEPLAYER_load1_OutLow      (ld14),
        .SC_STATEMACHINEPLAYER_shiftselection_Out(sh4),
        .SC_STATEMACHINEPLAYER_row_Out           (row4),
        .SC_STATEMACHINEPLAYER_col_Out           (col4)
    );

    // Inputs {rst, start, up, down, left, right}; buttons active low.
    localparam logic [5:0] I_NONE = 6'b011111;
    localparam logic [5:0] I_RST  = 6'b111111;
    localparam logic [5:0] I_ST   = 6'b001111;
    localparam logic [5:0] I_UP   = 6'b010111;
    localparam logic [5:0] I_DN   = 6'b011011;
    localparam logic [5:0] I_LF   = 6'b011101;
    localparam logic [5:0] I_RT   = 6'b011110;
    // Outputs {clear, load0, load1, shift[1:0]}.
    localparam logic [4:0] O_IDL  = 5'b11111;
    localparam logic [4:0] O_CLR  = 5'b01111;
    localparam logic [4:0] O_L0   = 5'b10111;
    localparam logic [4:0] O_L1   = 5'b11011;
    localparam logic [4:0] O_SL   = 5'b11101;
    localparam logic [4:0] O_SR   = 5'b11110;

    typedef struct packed {
        logic [5:0] in;
        logic [4:0] out;
        logic [2:0] row;
        logic [2:0] col;
    } step_t;

    step_t       plan[$];
    logic [10:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic add(input logic [5:0] in, input logic [4:0] out, input int r, input int c);
        step_t s;
        s.in  = in;
        s.out = out;
        s.row = 3'(r);
        s.col = 3'(c);
        plan.push_back(s);
    endtask

    task automatic apply(input logic [5:0] in);
        {rst, st_n, up_n, dn_n, lf_n, rt_n} = in;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step_t cur;
        logic [10:0] got, want;
        int n = 0;
        add(I_RST, O_IDL, 0, 3);
        add(I_RST, O_IDL, 0, 3);
        add(I_NONE, O_IDL, 0, 3);
        add(I_ST, O_CLR, 0, 3);
        add(I_NONE, O_IDL, 0, 3);
        add(I_NONE, O_IDL, 0, 3);
        while (plan.size() > 0) begin
            cur = plan.pop_front();
            exp_q.push_back({cur.out, cur.row, cur.col});
            apply(cur.in);
            got  = {clr0, ld00, ld10, sh0, row0, col0};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset step %0d: got %b want %b", n, got, want);
            end
            n++;
        end
    endtask

    task automatic test_up_hold();
        step_t cur;
        logic [10:0] got, want;
        int n = 0;
        add(I_UP, O_L0, 0, 3);
        add(I_UP, O_IDL, 1, 3);
        add(I_UP, O_IDL, 1, 3);
        add(I_UP, O_IDL, 1, 3);
        add(I_NONE, O_IDL, 1, 3);
        for (int r = 1; r < 7; r++) begin
            add(I_UP, O_L0, r, 3);
            add(I_NONE, O_IDL, r + 1, 3);
            add(I_NONE, O_IDL, r + 1, 3);
        end
        add(I_UP, O_IDL, 7, 3);
        add(I_NONE, O_IDL, 7, 3);
        add(I_DN, O_L1, 7, 3);
        add(I_NONE, O_IDL, 6, 3);
        add(I_NONE, O_IDL, 6, 3);
        while (plan.size() > 0) begin
            cur = plan.pop_front();
            exp_q.push_back({cur.out, cur.row, cur.col});
            apply(cur.in);
            got  = {clr0, ld00, ld10, sh0, row0, col0};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL up_hold step %0d: got %b want %b", n, got, want);
            end
            n++;
        end
    endtask

    task automatic test_edge_skip();
        step_t cur;
        logic [10:0] got, want;
        int n = 0;
        add(I_RST, O_IDL, 0, 3);
        add(I_NONE, O_IDL, 0, 3);
        add(I_DN & I_LF, O_SL, 0, 3);
        add(I_NONE, O_IDL, 0, 2);
        add(I_NONE, O_IDL, 0, 2);
        add(I_LF, O_SL, 0, 2);
        add(I_NONE, O_IDL, 0, 1);
        add(I_NONE, O_IDL, 0, 1);
        add(I_LF, O_SL, 0, 1);
        add(I_NONE, O_IDL, 0, 0);
        add(I_NONE, O_IDL, 0, 0);
        add(I_DN & I_LF, O_IDL, 0, 0);
        add(I_NONE, O_IDL, 0, 0);
        while (plan.size() > 0) begin
            cur = plan.pop_front();
            exp_q.push_back({cur.out, cur.row, cur.col});
            apply(cur.in);
            got  = {clr0, ld00, ld10, sh0, row0, col0};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL edge_skip step %0d: got %b want %b", n, got, want);
            end
            n++;
        end
    endtask

    task automatic test_repeat();
        step_t cur;
        logic [10:0] got, want;
        int n = 0;
        int moves;
        add(I_RST, O_IDL, 0, 3);
        add(I_NONE, O_IDL, 0, 3);
        // Pulses at held cycles 1, 6, 11, 16; col shows the moves completed so far.
        for (int k = 1; k <= 30; k++) begin
            moves = (k + 3) / 5;
            if (moves > 4) moves = 4;
            add(I_RT, ((k % 5) == 1 && k <= 16) ? O_SR : O_IDL, 0, 3 + moves);
        end
        add(I_NONE, O_IDL, 0, 7);
        add(I_NONE, O_IDL, 0, 7);
        while (plan.size() > 0) begin
            cur = plan.pop_front();
            exp_q.push_back({cur.out, cur.row, cur.col});
            apply(cur.in);
            got  = {clr4, ld04, ld14, sh4, row4, col4};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL repeat step %0d: got %b want %b", n, got, want);
            end
            n++;
        end
    endtask

    task automatic test_start_up();
        step_t cur;
        logic [10:0] got, want;
        int n = 0;
        add(I_UP, O_L0, 0, 7);
        add(I_NONE, O_IDL, 1, 7);
        add(I_NONE, O_IDL, 1, 7);
        add(I_ST & I_UP, O_CLR, 1, 7);
        for (int k = 0; k < 9; k++) add(I_ST & I_UP, O_IDL, 0, 3);
        add(I_NONE, O_IDL, 0, 3);
        add(I_UP, O_L0, 0, 3);
        add(I_NONE, O_IDL, 1, 3);
        add(I_NONE, O_IDL, 1, 3);
        while (plan.size() > 0) begin
            cur = plan.pop_front();
            exp_q.push_back({cur.out, cur.row, cur.col});
            apply(cur.in);
            got  = {clr4, ld04, ld14, sh4, row4, col4};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL start_up step %0d: got %b want %b", n, got, want);
            end
            n++;
        end
    endtask

    task automatic test_reset_mid_pulse();
        step_t cur;
        logic [10:0] got, want;
        int n = 0;
        add(I_RST, O_IDL, 0, 3);
        add(I_NONE, O_IDL, 0, 3);
        for (int r = 0; r < 4; r++) begin
            add(I_UP, O_L0, r, 3);
            add(I_NONE, O_IDL, r + 1, 3);
            add(I_NONE, O_IDL, r + 1, 3);
        end
        add(I_UP, O_L0, 4, 3);
        add(I_RST, O_IDL, 0, 3);
        add(I_RST, O_IDL, 0, 3);
        add(I_NONE, O_IDL, 0, 3);
        add(I_NONE, O_IDL, 0, 3);
        while (plan.size() > 0) begin
            cur = plan.pop_front();
            exp_q.push_back({cur.out, cur.row, cur.col});
            apply(cur.in);
            got  = {clr0, ld00, ld10, sh0, row0, col0};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset_mid_pulse step %0d: got %b want %b", n, got, want);
            end
            n++;
        end
    endtask

    initial begin
        test_reset();
        test_up_hold();
        test_edge_skip();
        test_repeat();
        test_start_up();
        test_reset_mid_pulse();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
